serial_frame_tx: RTL and testbench

//  Upstream transmitter for the serial receive state machine. Accepts a frame request
//  (payload bit count) and a byte stream of payload, then serialises onto one line:

---
 rtl/serial_frame_tx.sv | 190 +++++++++++++++++++
 tb/tb_serial_frame_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Serialises start pattern, 8-bit length and payload MSB-first onto ser_out; first bit one cycle after request accept.
// Payload backpressure via pld_ready over a two-byte buffer; a missing byte zero-fills the rest of the frame (underrun).
module serial_frame_tx #(
   parameter int                 START_W   = 4,
   parameter logic [START_W-1:0] START_PAT = 4'b0110,
   parameter int                 GAP_CYC   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [7:0] req_len,
   output logic       req_ready,
   input  logic       pld_valid,
   input  logic [7:0] pld_data,
   output logic       pld_ready,
   output logic       ser_out,
   output logic       ser_active,
   output logic       frame_done,
   output logic       underrun
);

   typedef enum logic [2:0] {IDLE, START, LEN, DATA, GAP} state_t;

   localparam logic [7:0] PAT_MSB = 8'(START_PAT) << (8 - START_W);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] bitcnt_q, bitcnt_d;
   logic [7:0] len_q, len_d;
   logic [7:0] cur_q, cur_d;
   logic [7:0] nxt_q, nxt_d;
   logic       nxt_vld_q, nxt_vld_d;
   logic [5:0] fetched_q, fetched_d;
   logic       ser_out_q, ser_out_d;
   logic       ser_active_q, ser_active_d;
   logic       frame_done_q, frame_done_d;
   logic       underrun_q, underrun_d;

   logic [5:0] bytes_needed;
   logic       busy, last_bit, end_active, boundary, xfer, starve, pld_fire;

   assign bytes_needed = {1'b0, len_q[7:3]} + {5'b0, |len_q[2:0]};
   assign busy         = (state_q == START) || (state_q == LEN) || (state_q == DATA);
   assign last_bit     = (state_q == DATA) && (bitcnt_q == len_q - 8'd1);
   assign end_active   = ((state_q == LEN) && (idx_q == 3'd7) && (len_q == 8'd0)) || last_bit;
   // Byte boundary: cycle whose successor shows bit 0 of a new payload byte.
   assign boundary     = ((state_q == LEN) && (idx_q == 3'd7) && (len_q != 8'd0)) ||
                         ((state_q == DATA) && !last_bit && (bitcnt_q[2:0] == 3'd7));
   assign xfer         = boundary && nxt_vld_q;
   assign starve       = boundary && !nxt_vld_q;
   assign pld_ready    = busy && (!nxt_vld_q || xfer) && (fetched_q < bytes_needed) &&
                         !underrun_q && !starve;
   assign pld_fire     = pld_valid && pld_ready;
   assign req_ready    = (state_q == IDLE);

   assign ser_out    = ser_out_q;
   assign ser_active = ser_active_q;
   assign frame_done = frame_done_q;
   assign underrun   = underrun_q;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      bitcnt_d     = bitcnt_q;
      len_d        = len_q;
      cur_d        = cur_q;
      nxt_d        = nxt_q;
      fetched_d    = fetched_q;
      ser_out_d    = ser_out_q;
      ser_active_d = ser_active_q;
      frame_done_d = 1'b0;
      underrun_d   = underrun_q;
      nxt_vld_d    = pld_fire || (nxt_vld_q && !xfer);

      if (pld_fire) begin
         nxt_d     = pld_data;
         fetched_d = fetched_q + 6'd1;
      end

      if (boundary) begin
         if (nxt_vld_q) begin
            cur_d     = nxt_q;
            ser_out_d = nxt_q[7];
         end else begin
            cur_d      = 8'd0;
            ser_out_d  = 1'b0;
            underrun_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d      = START;
               len_d        = req_len;
               idx_d        = 3'd0;
               bitcnt_d     = 8'd0;
               cur_d        = 8'd0;
               fetched_d    = 6'd0;
               nxt_vld_d    = 1'b0;
               underrun_d   = 1'b0;
               ser_out_d    = PAT_MSB[7];
               ser_active_d = 1'b1;
            end
         end
         START: begin
            if (idx_q == 3'(START_W - 1)) begin
               state_d   = LEN;
               idx_d     = 3'd0;
               ser_out_d = len_q[7];
            end else begin
               idx_d     = idx_q + 3'd1;
               ser_out_d = PAT_MSB[3'd6 - idx_q];
            end
         end
         LEN: begin
            if (idx_q == 3'd7) begin
               idx_d    = 3'd0;
               bitcnt_d = 8'd0;
               if (len_q != 8'd0) state_d = DATA;
            end else begin
               idx_d     = idx_q + 3'd1;
               ser_out_d = len_q[3'd6 - idx_q];
            end
         end
         DATA: begin
            if (!last_bit) begin
               bitcnt_d = bitcnt_q + 8'd1;
               if (!boundary) begin
                  cur_d     = {cur_q[6:0], 1'b0};
                  ser_out_d = cur_q[6];
               end
            end
         end
         GAP: begin
            // Leave GAP while the final gap cycle is on the line so a held request starts right after it.
            if (bitcnt_q == 8'(GAP_CYC - 2)) begin
               state_d      = IDLE;
               frame_done_d = 1'b1;
            end else begin
               bitcnt_d = bitcnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (end_active) begin
         ser_out_d    = 1'b1;
         ser_active_d = 1'b0;
         bitcnt_d     = 8'd0;
         if (GAP_CYC == 1) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
         end else begin
            state_d = GAP;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         idx_q        <= 3'd0;
         bitcnt_q     <= 8'd0;
         len_q        <= 8'd0;
         cur_q        <= 8'd0;
         nxt_q        <= 8'd0;
         nxt_vld_q    <= 1'b0;
         fetched_q    <= 6'd0;
         ser_out_q    <= 1'b1;
         ser_active_q <= 1'b0;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         bitcnt_q     <= bitcnt_d;
         len_q        <= len_d;
         cur_q        <= cur_d;
         nxt_q        <= nxt_d;
         nxt_vld_q    <= nxt_vld_d;
         fetched_q    <= fetched_d;
         ser_out_q    <= ser_out_d;
         ser_active_q <= ser_active_d;
         frame_done_q <= frame_done_d;
         underrun_q   <= underrun_d;
      end
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: expected line bits and frame lengths are queued at stimulus time
// and a free-running monitor pops and compares them whenever ser_active / frame_done are seen.
module tb_serial_frame_tx;

   localparam int         GAP = 2;
   localparam logic [3:0] PAT = 4'b0110;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid, req_ready;
   logic [7:0] req_len;
   logic       pld_valid, pld_ready;
   logic [7:0] pld_data;
   logic       ser_out, ser_active, frame_done, underrun;

   int         n_cmp = 0;
   int         n_err = 0;
   logic       exp_q[$];
   int         alen_q[$];
   logic [7:0] src[$];
   int         hs_cnt = 0;
   bit         b2b_mode = 1'b0;
   int         rises = 0;
   int         act_cnt = 0;
   int         gap_cnt = 0;
   logic       prev_act = 1'b0;
   logic       fire;

   always #5 clk = ~clk;

   serial_frame_tx #(.START_W(4), .START_PAT(4'b0110), .GAP_CYC(GAP)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_len    (req_len),
      .req_ready  (req_ready),
      .pld_valid  (pld_valid),
      .pld_data   (pld_data),
      .pld_ready  (pld_ready),
      .ser_out    (ser_out),
      .ser_active (ser_active),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [7:0] len, input logic [7:0] b0, input logic [7:0] b1,
                             input int avail);
      logic [7:0] bb[2];
      logic [7:0] b;
      bb[0] = b0;
      bb[1] = b1;
      for (int i = 3; i >= 0; i--) exp_q.push_back(PAT[i]);
      for (int i = 7; i >= 0; i--) exp_q.push_back(len[i]);
      for (int k = 0; k < int'(len); k++) begin
         b = ((k / 8) < avail) ? bb[k / 8] : 8'h00;
         exp_q.push_back(b[7 - (k % 8)]);
      end
      alen_q.push_back(12 + int'(len));
   endtask

   task automatic do_req(input logic [7:0] len);
      int  n;
      logic ok;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_len   = len;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = req_ready;
         @(posedge clk); #1;
         n++;
      end
      req_valid = 1'b0;
      if (!ok) chk("req_accept_timeout", 0, 1);
   endtask

   task automatic wait_done(output int cyc, output int rdy);
      cyc = 0;
      rdy = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (pld_ready) rdy++;
      end while (!frame_done && cyc < 400);
      if (!frame_done) chk("frame_done_timeout", 0, 1);
   endtask

   // Payload source: presents src[0] until accepted.
   initial begin
      pld_valid = 1'b0;
      pld_data  = 8'h00;
      forever begin
         @(negedge clk);
         fire = pld_valid && pld_ready;
         @(posedge clk);
         if (fire && src.size() > 0) begin
            void'(src.pop_front());
            hs_cnt++;
         end
         #1;
         pld_valid = (src.size() > 0);
         pld_data  = (src.size() > 0) ? src[0] : 8'h00;
      end
   end

   // Monitor: line bits, active length, gap length, back-to-back spacing.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            act_cnt  = 0;
            gap_cnt  = 0;
            prev_act = 1'b0;
         end else begin
            if (ser_active) begin
               if (!prev_act && b2b_mode) begin
                  rises++;
                  if (rises == 2) chk("b2b_idle_gap", gap_cnt, GAP);
               end
               act_cnt++;
               gap_cnt = 0;
               if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
               else chk("ser_bit", ser_out, exp_q.pop_front());
            end else begin
               gap_cnt++;
            end
            if (frame_done) begin
               chk("gap_len", gap_cnt, GAP);
               if (alen_q.size() == 0) chk("unexpected_frame_done", 1, 0);
               else chk("active_len", act_cnt, alen_q.pop_front());
               act_cnt = 0;
            end
            prev_act = ser_active;
         end
      end
   end

   initial begin
      int cyc, rdy, n, hs;
      rst       = 1'b0;
      req_valid = 1'b0;
      req_len   = 8'h00;

      // Reset state
      @(negedge clk);
      chk("rst_ser_out", ser_out, 1);
      chk("rst_ser_active", ser_active, 0);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_pld_ready", pld_ready, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_underrun", underrun, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // len=16, bytes preloaded (also offered in IDLE, must wait for START)
      src.push_back(8'hA5);
      src.push_back(8'h3C);
      hs_cnt = 0;
      push_frame(8'd16, 8'hA5, 8'h3C, 2);
      repeat (3) @(posedge clk);
      chk("idle_refuses_bytes", hs_cnt, 0);
      do_req(8'd16);
      wait_done(cyc, rdy);
      chk("len16_done_cycle", cyc, 30);
      chk("len16_pld_hs", hs_cnt, 2);

      // len=0: no payload fetch at all
      push_frame(8'd0, 8'h00, 8'h00, 0);
      do_req(8'd0);
      wait_done(cyc, rdy);
      chk("len0_pld_ready_cycles", rdy, 0);
      chk("len0_done_cycle", cyc, 14);

      // len=11, partial final byte, third byte refused
      src.push_back(8'hFF);
      src.push_back(8'hE0);
      src.push_back(8'h77);
      hs_cnt = 0;
      push_frame(8'd11, 8'hFF, 8'hE0, 2);
      do_req(8'd11);
      wait_done(cyc, rdy);
      chk("len11_done_cycle", cyc, 25);
      repeat (3) @(posedge clk);
      chk("len11_pld_hs", hs_cnt, 2);
      chk("len11_leftover", src.size(), 1);
      #2 src.delete();

      // len=24, second byte withheld -> underrun, zero fill, late byte refused
      src.push_back(8'hC3);
      hs_cnt = 0;
      push_frame(8'd24, 8'hC3, 8'h00, 1);
      do_req(8'd24);
      n = 0;
      while (!underrun && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("underrun_set", underrun, 1);
      src.push_back(8'h55);
      wait_done(cyc, rdy);
      chk("len24_done_cycle_plus", cyc > 0, 1);
      chk("underrun_pld_hs", hs_cnt, 1);
      chk("underrun_sticky", underrun, 1);
      @(posedge clk); #2 src.delete();

      // Back-to-back with req_valid held high
      src.push_back(8'h9C);
      src.push_back(8'hA5);
      hs_cnt = 0;
      push_frame(8'd4, 8'h9C, 8'h00, 1);
      push_frame(8'd4, 8'hA5, 8'h00, 1);
      @(posedge clk); #1;
      b2b_mode  = 1'b1;
      rises     = 0;
      req_valid = 1'b1;
      req_len   = 8'd4;
      hs = 0;
      n  = 0;
      while (hs < 2 && n < 300) begin
         @(negedge clk);
         if (req_ready) hs++;
         @(posedge clk); #1;
         n++;
      end
      req_valid = 1'b0;
      chk("b2b_handshakes", hs, 2);
      chk("underrun_cleared", underrun, 0);
      wait_done(cyc, rdy);
      b2b_mode = 1'b0;
      chk("b2b_rises", rises, 2);
      chk("b2b_pld_hs", hs_cnt, 2);

      // Reset mid-DATA while underrun is set
      src.push_back(8'h11);
      push_frame(8'd24, 8'h11, 8'h00, 1);
      do_req(8'd24);
      repeat (22) @(posedge clk);
      #1;
      chk("pre_reset_underrun", underrun, 1);
      chk("pre_reset_active", ser_active, 1);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ser_out", ser_out, 1);
      chk("abort_ser_active", ser_active, 0);
      chk("abort_req_ready", req_ready, 1);
      chk("abort_underrun", underrun, 0);
      chk("abort_pld_ready", pld_ready, 0);
      exp_q.delete();
      alen_q.delete();
      src.delete();
      @(posedge clk); #1 rst = 1'b1;

      // Recovery frame after abort
      src.push_back(8'h5A);
      push_frame(8'd8, 8'h5A, 8'h00, 1);
      do_req(8'd8);
      wait_done(cyc, rdy);
      chk("recover_done_cycle", cyc, 22);

      repeat (3) @(posedge clk);
      chk("leftover_bits", exp_q.size(), 0);
      chk("leftover_frames", alen_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
